present_dec_ctrl: RTL and testbench
===================================

# present_dec_ctrl

Iterative PRESENT-80 decryption controller that sequences one round per clock. It accepts a 64-bit ciphertext and 80-bit key over a valid/ready handshake. It first runs the forward key schedule to derive round key 32, then walks 31 inverse rounds (inverse pLayer, inverse sLayer, inverse key update) and presents the plaintext over a second valid/ready handshake. It is the sequencing layer above the inverse permutation and inverse S-box datapath, and is the decryption counterpart of the encryption round controller.

## Interface
Parameters:
- None. The round count (31) and key width (80) are fixed constants in the shared package.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ciphertext/key offered.
- `in_ready` out 1: block accepts input; high only in IDLE.
- `ciphertext` in 64: sampled on the accept edge.
- `key` in 80: user key (K[79:0]), sampled on the accept edge.
- `out_valid` out 1: plaintext available; high only in DONE.
- `out_ready` in 1: consumer takes plaintext.
- `plaintext` out 64: equals `state ^ keyreg[79:16]`; defined only while `out_valid` is high.
- `busy` out 1: high in KEYEXP or ROUND.

## Operation
- Registers:
  - `state[63:0]`
  - `keyreg[79:0]`
  - `rc[4:0]`: round counter
  - `fsm`: IDLE / KEYEXP / ROUND / DONE
- Accept: on an edge with `in_valid & in_ready`, load `state <= ciphertext`, `keyreg <= key`, `rc <= 1`, and go to KEYEXP.
- Forward key step fwd(k, i):
  - k <<<= 61
  - k[79:76] = S(k[79:76])
  - k[19:15] ^= i
- Inverse key step inv(k, i):
  - k[19:15] ^= i
  - k[79:76] = S⁻¹(k[79:76])
  - k >>>= 61
- KEYEXP:
  - Each cycle `keyreg <= fwd(keyreg, rc)`.
  - If `rc == 31`: set `rc <= 31` and go to ROUND. After this `keyreg` holds the round-32 register.
  - Otherwise `rc <= rc + 1`.
- ROUND:
  - Each cycle `state <= S⁻¹(P⁻¹(state ^ keyreg[79:16]))`, applied nibble-wise after the bit permutation.
  - Each cycle `keyreg <= inv(keyreg, rc)`.
  - If `rc == 1`: go to DONE. Otherwise `rc <= rc - 1`.
  - P⁻¹: out[4·(j mod 16) + j/16] = in[j].
- DONE:
  - `out_valid = 1`; `keyreg` holds round key 1.
  - On `out_ready`, go to IDLE.
  - `state` and `keyreg` hold their values until then. Back-pressure is unlimited.
- IDLE: `in_ready = 1`. Registers hold stale values; `plaintext` is don't-care.
- No overlap: a new input cannot be accepted in the cycle DONE→IDLE. `in_ready` rises the cycle after the output handshake.
- `in_valid` outside IDLE is ignored. Input buses are not sampled after the accept edge.
- Reset (any time, including mid-ROUND):
  - `fsm = IDLE`, `rc = 0`, `state = 0`, `keyreg = 0`.
  - `in_ready = 1`, `out_valid = 0`, `busy = 0`.
  - An in-flight operation is discarded; no partial output.
- `rc` arithmetic is 5-bit unsigned and never wraps: range 1..31 in KEYEXP and ROUND.

## Timing
- The accept edge is E0.
- KEYEXP occupies E1..E31 (31 updates).
- ROUND occupies E32..E62.
- `out_valid` rises after E62, i.e. 62 cycles after acceptance.
- `plaintext` is stable from then until the handshake edge.
- Throughput: one block per 64 cycles minimum (accept + 62 + handshake).
- `busy` is high exactly during E1..E62 intervals.
- `in_ready`, `out_valid` and `busy` are decoded from registered `fsm`, with no combinational path from inputs.
- `plaintext` is combinational from registers only.

## Structure
- Package `present_pkg`:
  - `SBOX[16]` and `SBOX_INV[16]` constant tables.
  - `ROUNDS = 31`, `KEY_W = 80`, `BLK_W = 64`.
  - The fsm enum typedef.
- Sub-module `present_key_step`: combinational; inputs `k[79:0]`, `rc[4:0]`, `dir`; output next key.
  - Instantiated once and shared between KEYEXP (forward) and ROUND (inverse).
- Inverse pLayer and inverse sLayer are inline combinational logic in the top.

## Test plan
- Key 0, ciphertext 5579C1387B228445 → `plaintext` 0000000000000000, `out_valid` exactly 62 cycles after accept.
- Key FFFFFFFFFFFFFFFFFFFF, ciphertext E72C46C0F5945049 → 0000000000000000.
- Key 0, ciphertext A112FFC72F68417B → FFFFFFFFFFFFFFFF.
- Key all-ones, ciphertext 3333DCD3213210D2 → FFFFFFFFFFFFFFFF.
- Hold `out_ready = 0` for 20 cycles in DONE:
  - `plaintext` is stable and `in_ready` stays 0.
  - A new `in_valid` is ignored.
  - After the handshake, `in_ready` rises next cycle and the next vector decrypts correctly.
- Assert `reset_n = 0` at ROUND cycle 10:
  - All outputs are at their reset values immediately.
  - After release, vector 1 decrypts correctly with full 62-cycle latency.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants, S-box tables and controller state type for the PRESENT-80 cores.
package present_pkg;

  localparam int ROUNDS = 31;
  localparam int KEY_W  = 80;
  localparam int BLK_W  = 64;

  localparam logic [4:0] RC_FIRST = 5'd1;
  localparam logic [4:0] RC_LAST  = 5'(ROUNDS);

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_INV = 1'b1;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    ROUND,
    DONE
  } fsm_t;

endpackage

// File: rtl/present_key_step.sv
// One PRESENT-80 key-schedule step, forward or inverse, selected by dir.
module present_key_step
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] k,
  input  logic [4:0]       rc,
  input  logic             dir,
  output logic [KEY_W-1:0] k_next
);

  logic [KEY_W-1:0] fwd_rot;
  logic [KEY_W-1:0] fwd_key;
  logic [KEY_W-1:0] inv_pre;
  logic [KEY_W-1:0] inv_key;

  // Forward: rotate left by 61, S-box the top nibble, fold in the counter.
  assign fwd_rot = {k[18:0], k[79:19]};
  assign fwd_key = {SBOX[fwd_rot[79:76]], fwd_rot[75:20],
                    fwd_rot[19:15] ^ rc, fwd_rot[14:0]};

  // Inverse undoes the forward steps in reverse order, ending with a right rotate by 61.
  assign inv_pre = {SBOX_INV[k[79:76]], k[75:20], k[19:15] ^ rc, k[14:0]};
  assign inv_key = {inv_pre[60:0], inv_pre[79:61]};

  assign k_next = (dir == DIR_INV) ? inv_key : fwd_key;

endmodule

// File: rtl/present_dec_ctrl.sv
// Iterative PRESENT-80 decryption: expands the key forward to round 32, then
// runs 31 inverse rounds, one per clock, between two valid/ready handshakes.
module present_dec_ctrl
  import present_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ciphertext,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] plaintext,
  output logic             busy
);

  fsm_t             fsm;
  fsm_t             fsm_next;
  logic [BLK_W-1:0] state;
  logic [KEY_W-1:0] keyreg;
  logic [4:0]       rc;
  logic [KEY_W-1:0] key_next;
  logic             key_dir;
  logic [BLK_W-1:0] round_in;
  logic [BLK_W-1:0] perm;
  logic [BLK_W-1:0] state_next;

  assign key_dir = (fsm == ROUND) ? DIR_INV : DIR_FWD;

  present_key_step u_key_step (
    .k      (keyreg),
    .rc     (rc),
    .dir    (key_dir),
    .k_next (key_next)
  );

  // Key addition doubles as the final whitening once keyreg holds round key 1.
  assign round_in  = state ^ keyreg[79:16];
  assign plaintext = round_in;

  always_comb begin
    perm = '0;
    for (int j = 0; j < BLK_W; j++) begin
      perm[4*(j%16) + j/16] = round_in[j];
    end
  end

  always_comb begin
    state_next = '0;
    for (int n = 0; n < BLK_W/4; n++) begin
      state_next[4*n +: 4] = SBOX_INV[perm[4*n +: 4]];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (in_valid)        fsm_next = KEYEXP;
      KEYEXP:  if (rc == RC_LAST)   fsm_next = ROUND;
      ROUND:   if (rc == RC_FIRST)  fsm_next = DONE;
      DONE:    if (out_ready)       fsm_next = IDLE;
      default:                      fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm)
      IDLE:    in_ready  = 1'b1;
      KEYEXP:  busy      = 1'b1;
      ROUND:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // rc counts up through the schedule and back down through the rounds, saturating at the ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= '0;
      keyreg <= '0;
      rc     <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state  <= ciphertext;
            keyreg <= key;
            rc     <= RC_FIRST;
          end
        end
        KEYEXP: begin
          keyreg <= key_next;
          if (rc != RC_LAST) rc <= rc + 5'd1;
        end
        ROUND: begin
          state  <= state_next;
          keyreg <= key_next;
          if (rc != RC_FIRST) rc <= rc - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec_ctrl.sv
// Scoreboard bench for present_dec_ctrl: known-answer and random vectors,
// output back-pressure and a mid-round reset, checked against a PRESENT encryptor model.
module tb_present_dec_ctrl;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic        busy;

  typedef struct {
    logic [63:0] pt;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   check_count = 0;
  int   pass_count = 0;
  int   hold_req = 0;

  present_dec_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [3:0] sbox_of(input logic [3:0] x);
    logic [63:0] tbl;
    int idx;
    tbl = 64'hC56B90AD3EF84712;
    idx = 63 - 4 * int'(x);
    return tbl[idx -: 4];
  endfunction

  // Straight PRESENT-80 encryption, used to build ciphertexts for random plaintexts.
  function automatic logic [63:0] present_encrypt(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [63:0] p;
    logic [79:0] kr;
    s  = pt;
    kr = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sbox_of(s[4*n +: 4]);
      p = '0;
      for (int j = 0; j < 64; j++) p[16*(j%4) + j/4] = t[j];
      s  = p;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sbox_of(kr[79:76]);
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] ct, input logic [79:0] k,
                               input logic [63:0] exp_pt, output int acc);
    int   waited;
    exp_t item;
    waited = 0;
    acc = -1;
    @(negedge clock);
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("in_ready_wait", 80'(in_ready), 80'(1));
    if (in_ready) begin
      in_valid   = 1'b1;
      ciphertext = ct;
      key        = k;
      acc        = cyc + 1;
      item.pt    = exp_pt;
      item.acc   = acc;
      sb_q.push_back(item);
      @(negedge clock);
      in_valid   = 1'b0;
      ciphertext = {$urandom(), $urandom()};
      key        = {$urandom(), $urandom(), 16'($urandom())};
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_pending", 80'(sb_q.size()), 80'(0));
  endtask

  // Monitor: pops the scoreboard when plaintext appears, then performs the output handshake.
  initial begin
    exp_t        item;
    logic [63:0] held;
    int          hold;
    out_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 80'(out_valid), 80'(0));
        end else begin
          item = sb_q.pop_front();
          checkOutput("latency", 80'(cyc - item.acc), 80'(62));
          checkOutput("plaintext", 80'(plaintext), 80'(item.pt));
          held = plaintext;
          hold = hold_req;
          for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            checkOutput("hold_plaintext", 80'(plaintext), 80'(held));
            checkOutput("hold_out_valid", 80'(out_valid), 80'(1));
            checkOutput("hold_in_ready", 80'(in_ready), 80'(0));
          end
          hold_req  = 0;
          out_ready = 1'b1;
          @(negedge clock);
          out_ready = 1'b0;
          checkOutput("in_ready_after_hs", 80'(in_ready), 80'(1));
          checkOutput("out_valid_after_hs", 80'(out_valid), 80'(0));
        end
      end
    end
  end

  initial begin
    logic [63:0] kv_ct  [4];
    logic [79:0] kv_key [4];
    logic [63:0] kv_pt  [4];
    logic [63:0] pt;
    logic [79:0] k;
    int          acc;
    int          n;

    kv_ct[0] = 64'h5579C1387B228445; kv_key[0] = '0; kv_pt[0] = '0;
    kv_ct[1] = 64'hE72C46C0F5945049; kv_key[1] = '1; kv_pt[1] = '0;
    kv_ct[2] = 64'hA112FFC72F68417B; kv_key[2] = '0; kv_pt[2] = '1;
    kv_ct[3] = 64'h3333DCD3213210D2; kv_key[3] = '1; kv_pt[3] = '1;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    ciphertext = '0;
    key        = '0;
    #1;
    checkOutput("reset_in_ready", 80'(in_ready), 80'(1));
    checkOutput("reset_out_valid", 80'(out_valid), 80'(0));
    checkOutput("reset_busy", 80'(busy), 80'(0));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      hold_req = 0;
      applyStimulus(kv_ct[i], kv_key[i], kv_pt[i], acc);
      drain();
    end

    // Back-pressure: 20 stalled cycles in DONE while a new request is waved at the input.
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), 16'($urandom())};
    hold_req = 20;
    applyStimulus(present_encrypt(pt, k), k, pt, acc);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("out_valid_wait", 80'(out_valid), 80'(1));
    repeat (10) begin
      in_valid   = 1'b1;
      ciphertext = {$urandom(), $urandom()};
      key        = {$urandom(), $urandom(), 16'($urandom())};
      @(negedge clock);
    end
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 6; i++) begin
      pt = {$urandom(), $urandom()};
      k  = {$urandom(), $urandom(), 16'($urandom())};
      hold_req = int'($urandom_range(0, 3));
      applyStimulus(present_encrypt(pt, k), k, pt, acc);
      drain();
    end

    // Reset in the middle of the inverse rounds, then rerun the first vector.
    hold_req = 0;
    applyStimulus(kv_ct[0], kv_key[0], kv_pt[0], acc);
    n = 0;
    while (cyc < acc + 41 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("busy_in_round", 80'(busy), 80'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 80'(in_ready), 80'(1));
    checkOutput("midreset_out_valid", 80'(out_valid), 80'(0));
    checkOutput("midreset_busy", 80'(busy), 80'(0));
    sb_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(kv_ct[0], kv_key[0], kv_pt[0], acc);
    drain();

    repeat (2) @(negedge clock);
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
